instr_exec: RTL and testbench
=============================

# instr_exec

Instruction execution unit sitting at the consuming end of the feeder's instruction stream.
- Accepts one packed instruction word at a time over a valid/ready handshake and executes it against a private register file and data RAM.
- Reports branch redirects back to the feeder.
- Exposes the last written value as `Res`, and raises `done` on HLT.

## Interface
Parameters:
- `BUSW`, 32, data/operand width (power of two)
- `OPW`, 4, opcode width
- `NREG`, 16, register count (power of two)
- `NMEM`, 16, data RAM words (power of two)
- `PLLEN`, `OPW+2*BUSW+1`, instruction word width

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  synchronous active-high reset
- `instr`  in  PLLEN  packed instruction
- `instr_valid`  in  1  feeder presents `instr`
- `instr_ready`  out  1  unit accepts `instr` this cycle
- `bra_taken`  out  1  one-cycle pulse: branch taken
- `bra_target`  out  BUSW  instruction index to fetch next, valid with `bra_taken`
- `Res`  out  BUSW  value of most recent register/RAM write
- `done`  out  1  HLT executed; sticky until reset

## Operation
Instruction fields:
- bit 0: `srcIsLit`
- [BUSW:1]: `src`
- [2*BUSW:BUSW+1]: `dst`
- [PLLEN-1:2*BUSW+1]: opcode

Operand rules:
- S = `srcIsLit` ? `src` : reg[`src` mod NREG].
- Register indices use the low log2(NREG) bits; RAM addresses use the low log2(NMEM) bits.

Opcodes (shared codes NOP=0 … CMP=9; unknown codes execute as NOP):
- NOP: no state change.
- LD: reg[dst] <= `srcIsLit` ? `src` : mem[src].
- STR: mem[dst] <= S.
- ADD: reg[dst] <= reg[dst]+S mod 2^BUSW; C <= carry out.
- XOR: reg[dst] <= reg[dst]^S.
- ROT: reg[dst] <= rotate-left by S mod BUSW.
- SHF: reg[dst] <= logical shift-left by S; S ≥ BUSW gives 0.
- CMP: Z <= (reg[dst]==S); L <= (reg[dst]<S unsigned); registers unchanged.
- BRA: `dst[1:0]` selects the condition: 0 always, 1 Z, 2 C, 3 L. When the condition holds, `bra_target` <= S and `bra_taken` pulses.
- HLT: enter HALT.

`Res` is updated with the written data on every LD/STR/ADD/XOR/ROT/SHF. Flags Z, C, L reset to 0 and change only on ADD (C) and CMP (Z, L).

FSM states FETCH → EXEC → WB → FETCH:
- FETCH: `instr_ready`=1; a handshake (`instr_valid`&&`instr_ready`) latches `instr` and moves to EXEC; otherwise stays in FETCH.
- EXEC: reads operands and computes the result through the ALU; registers the result.
- WB: commits the register/RAM/flag write, pulses `bra_taken`, and updates `Res`. Next state is HALT for HLT, else FETCH.
- HALT: `instr_ready`=0 and `done`=1; leaves HALT only on `rst`.

## Timing
- Handshake in cycle N: EXEC in N+1, WB in N+2, `instr_ready` high again in N+3. Throughput is 1 instruction per 3 cycles.
- `bra_taken`/`bra_target` are valid in the WB cycle (N+2) only. The feeder must present the target in time for the next FETCH.
- HLT accepted at N: `done` rises at N+3 (first HALT cycle).
- The written value is visible on `Res` from N+3.
- Reset values: `instr_ready`=0, `bra_taken`=0, `bra_target`=0, `Res`=0, `done`=0, flags 0, registers 0, RAM 0. State after reset is FETCH, so `instr_ready`=1 one cycle after `rst` deasserts.
- `rst` asserted mid-instruction aborts it: no write commits and no branch pulse is issued.
- `instr_valid` is ignored outside FETCH. `instr` may change freely after acceptance.
- STR to mem[k] followed immediately by LD from mem[k] returns the new value, because the WB of the first instruction precedes the EXEC of the second.

## Structure
- Package `isa_pkg`:
  - opcode constants NOP…CMP
  - field offset/width localparams (`PLLEN`, src/dst/opcode LSBs)
  - BRA condition codes
  - FSM state encoding
- Sub-module `exec_alu` (combinational): inputs opcode, A=reg[dst], S; outputs result, carry, zero, less.
- `instr_exec` holds the FSM, register file, RAM, flags and outputs.

## Test plan
- Program STR 1,#2; LD 1,1; ADD 1,#3; STR 2,1; HLT issued back-to-back -> `Res`=5, mem[2]=5, `done`=1 from cycle 15 after the first handshake, `instr_ready` stays 0 afterwards.
- LD 0,#0xFFFFFFFF; ADD 0,#1 -> reg0=0, C=1, `Res`=0; then BRA cond=2 target #7 -> `bra_taken` pulses one cycle with `bra_target`=7.
- LD 3,#0x80000001; ROT 3,#33 -> reg3=0x00000003; SHF 3,#32 -> reg3=0.
- CMP with reg=4, S=#9 -> L=1, Z=0, registers and `Res` unchanged; BRA cond=1 -> no pulse; BRA cond=3 target #2 -> pulse with target 2.
- Hold `instr_valid`=0 for 10 cycles in FETCH, then opcode 4'hF -> behaves as NOP and `instr_ready` returns after 3 cycles.
- Assert `rst` during the EXEC of STR 5,#9 -> mem[5] stays 0, `bra_taken`=0, and all outputs read their reset values the next cycle.

Source files
------------

// File: rtl/isa_pkg.sv
// ============================================================================
//  Module      : isa_pkg
//  Description : Shared ISA definitions for the instruction execution unit:
//                opcodes, instruction field layout, branch condition codes
//                and the execution FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package isa_pkg;

    // Default field layout for the 32-bit datapath / 4-bit opcode build.
    // Parameterised instances derive their own offsets from BUSW/OPW.
    localparam int c_BUSW_DEF = 32;
    localparam int c_OPW_DEF  = 4;
    localparam int c_PLLEN    = c_OPW_DEF + 2 * c_BUSW_DEF + 1;
    localparam int c_LIT_BIT  = 0;
    localparam int c_SRC_LSB  = 1;
    localparam int c_DST_LSB  = c_BUSW_DEF + 1;
    localparam int c_OPC_LSB  = 2 * c_BUSW_DEF + 1;

    // Opcodes. Codes 10..15 (and any wider code) execute as NOP.
    localparam logic [3:0] c_OP_NOP = 4'd0;
    localparam logic [3:0] c_OP_LD  = 4'd1;
    localparam logic [3:0] c_OP_STR = 4'd2;
    localparam logic [3:0] c_OP_BRA = 4'd3;
    localparam logic [3:0] c_OP_XOR = 4'd4;
    localparam logic [3:0] c_OP_ADD = 4'd5;
    localparam logic [3:0] c_OP_ROT = 4'd6;
    localparam logic [3:0] c_OP_SHF = 4'd7;
    localparam logic [3:0] c_OP_HLT = 4'd8;
    localparam logic [3:0] c_OP_CMP = 4'd9;

    // Branch conditions, carried in dst[1:0] of a BRA.
    localparam logic [1:0] c_COND_ALWAYS = 2'd0;
    localparam logic [1:0] c_COND_Z      = 2'd1;
    localparam logic [1:0] c_COND_C      = 2'd2;
    localparam logic [1:0] c_COND_L      = 2'd3;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_WB    = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/exec_alu.sv
// ============================================================================
//  Module      : exec_alu
//  Description : Combinational ALU of the execution unit.
//                op     : 4-bit opcode (already NOP-folded by the caller)
//                a      : reg[dst]
//                s      : source operand (for LD, the loaded value)
//                result : value to be written back
//                carry  : carry out of a + s
//                zero   : a == s
//                less   : a < s (unsigned)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exec_alu
    import isa_pkg::*;
#(
    parameter int BUSW = 32
) (
    input  logic [3:0]      op,
    input  logic [BUSW-1:0] a,
    input  logic [BUSW-1:0] s,
    output logic [BUSW-1:0] result,
    output logic            carry,
    output logic            zero,
    output logic            less
);

    localparam int c_SHW = $clog2(BUSW);

    logic [BUSW:0]     w_sum;
    logic [2*BUSW-1:0] w_rot2;
    logic [c_SHW-1:0]  w_amt;
    logic              w_shf_big;

    assign w_amt     = s[c_SHW-1:0];
    // BUSW is a power of two, so S >= BUSW exactly when any bit above the
    // shift-amount field is set.
    assign w_shf_big = |s[BUSW-1:c_SHW];
    assign w_sum     = {1'b0, a} + {1'b0, s};
    // Rotating the doubled word left and keeping the top half gives
    // rotate-left by (S mod BUSW), including the zero-amount case.
    assign w_rot2    = {a, a} << w_amt;

    assign carry = w_sum[BUSW];
    assign zero  = (a == s);
    assign less  = (a < s);

    always_comb begin
        result = '0;
        case (op)
            c_OP_LD,
            c_OP_STR: result = s;
            c_OP_ADD: result = w_sum[BUSW-1:0];
            c_OP_XOR: result = a ^ s;
            c_OP_ROT: result = w_rot2[2*BUSW-1:BUSW];
            c_OP_SHF: result = w_shf_big ? '0 : (a << w_amt);
            default:  result = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/instr_exec.sv
// ============================================================================
//  Module      : instr_exec
//  Description : Multi-cycle instruction execution unit. Accepts one packed
//                instruction over valid/ready, executes it in
//                FETCH -> EXEC -> WB against a private register file and data
//                RAM, reports taken branches, and halts on HLT.
//  Ports       : clk, rst         - clock, synchronous active-high reset
//                instr            - packed {opcode, dst, src, srcIsLit}
//                instr_valid/ready- input handshake (ready only in FETCH)
//                bra_taken/target - one-cycle branch redirect in WB
//                Res              - value of most recent register/RAM write
//                done             - sticky HLT indication
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_exec
    import isa_pkg::*;
#(
    parameter int BUSW  = 32,
    parameter int OPW   = 4,    // must be >= 4
    parameter int NREG  = 16,
    parameter int NMEM  = 16,
    parameter int PLLEN = OPW + 2 * BUSW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PLLEN-1:0] instr,
    input  logic             instr_valid,
    output logic             instr_ready,
    output logic             bra_taken,
    output logic [BUSW-1:0]  bra_target,
    output logic [BUSW-1:0]  Res,
    output logic             done
);

    localparam int c_RW      = $clog2(NREG);
    localparam int c_MW      = $clog2(NMEM);
    localparam int c_SRC_OFS = 1;
    localparam int c_DST_OFS = BUSW + 1;
    localparam int c_OPC_OFS = 2 * BUSW + 1;
    // Highest dst bit that is ever decoded (register index, RAM address or
    // the two branch-condition bits).
    localparam int c_DUSE_A  = (c_RW > c_MW) ? c_RW : c_MW;
    localparam int c_DUSE    = (c_DUSE_A > 2) ? c_DUSE_A : 2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_live;      // first cycle after reset release seen
    logic [PLLEN-1:0]    r_instr;
    logic [BUSW-1:0]     r_regs [NREG];
    logic [BUSW-1:0]     r_mem  [NMEM];
    logic                r_z;
    logic                r_c;
    logic                r_l;
    logic [BUSW-1:0]     r_alu_res;
    logic                r_alu_c;
    logic                r_alu_z;
    logic                r_alu_l;
    logic                r_br_take;
    logic [BUSW-1:0]     r_bra_target;
    logic [BUSW-1:0]     r_res;

    // ------------------------------------------------------------------
    // Field decode of the latched instruction
    // ------------------------------------------------------------------
    logic [OPW-1:0]      w_opc;
    logic [3:0]          w_op;
    logic                w_lit;
    logic [BUSW-1:0]     w_src;
    logic [c_RW-1:0]     w_src_ridx;
    logic [c_MW-1:0]     w_src_midx;
    logic [c_RW-1:0]     w_dst_ridx;
    logic [c_MW-1:0]     w_dst_midx;
    logic [1:0]          w_cond_sel;
    logic                w_unused_dst;

    assign w_opc      = r_instr[c_OPC_OFS +: OPW];
    assign w_lit      = r_instr[0];
    assign w_src      = r_instr[c_SRC_OFS +: BUSW];
    assign w_src_ridx = r_instr[c_SRC_OFS +: c_RW];
    assign w_src_midx = r_instr[c_SRC_OFS +: c_MW];
    assign w_dst_ridx = r_instr[c_DST_OFS +: c_RW];
    assign w_dst_midx = r_instr[c_DST_OFS +: c_MW];
    assign w_cond_sel = r_instr[c_DST_OFS +: 2];

    // Upper dst bits carry no meaning; collected so they read as used.
    assign w_unused_dst = &{1'b0, r_instr[c_OPC_OFS-1 : c_DST_OFS+c_DUSE]};

    // Fold opcodes wider than the 4-bit ISA: any high bit set is unknown,
    // and unknown codes execute as NOP.
    generate
        if (OPW > 4) begin : g_op_wide
            assign w_op = (|w_opc[OPW-1:4]) ? c_OP_NOP : w_opc[3:0];
        end else begin : g_op_narrow
            assign w_op = w_opc[3:0];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Operands and ALU
    // ------------------------------------------------------------------
    logic [BUSW-1:0]     w_a;
    logic [BUSW-1:0]     w_s;
    logic [BUSW-1:0]     w_alu_s;
    logic [BUSW-1:0]     w_alu_res;
    logic                w_alu_c;
    logic                w_alu_z;
    logic                w_alu_l;
    logic                w_cond;

    assign w_a     = r_regs[w_dst_ridx];
    assign w_s     = w_lit ? w_src : r_regs[w_src_ridx];
    // LD takes its non-literal operand from RAM rather than the registers.
    assign w_alu_s = (w_op == c_OP_LD) ? (w_lit ? w_src : r_mem[w_src_midx]) : w_s;

    exec_alu #(
        .BUSW   (BUSW)
    ) u_alu (
        .op     (w_op),
        .a      (w_a),
        .s      (w_alu_s),
        .result (w_alu_res),
        .carry  (w_alu_c),
        .zero   (w_alu_z),
        .less   (w_alu_l)
    );

    // Flags are evaluated in EXEC; the previous instruction's WB has
    // already committed, so back-to-back CMP/ADD -> BRA sees fresh flags.
    always_comb begin
        w_cond = 1'b0;
        if (w_op == c_OP_BRA) begin
            case (w_cond_sel)
                c_COND_ALWAYS: w_cond = 1'b1;
                c_COND_Z:      w_cond = r_z;
                c_COND_C:      w_cond = r_c;
                c_COND_L:      w_cond = r_l;
                default:       w_cond = 1'b0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        instr_ready = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_FETCH: begin
                // Held low for the first cycle after reset release.
                instr_ready = r_live;
                if (instr_valid && r_live) begin
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_state_nxt = ST_WB;
            end
            ST_WB: begin
                w_state_nxt = (w_op == c_OP_HLT) ? ST_HALT : ST_FETCH;
            end
            ST_HALT: begin
                done = 1'b1;
            end
            default: begin
                w_state_nxt = ST_FETCH;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: latch, execute, write back
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_live       <= 1'b0;
            r_instr      <= '0;
            r_z          <= 1'b0;
            r_c          <= 1'b0;
            r_l          <= 1'b0;
            r_alu_res    <= '0;
            r_alu_c      <= 1'b0;
            r_alu_z      <= 1'b0;
            r_alu_l      <= 1'b0;
            r_br_take    <= 1'b0;
            r_bra_target <= '0;
            r_res        <= '0;
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
            for (int i = 0; i < NMEM; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_live <= 1'b1;

            if (r_state == ST_FETCH && instr_valid && r_live) begin
                r_instr <= instr;
            end

            if (r_state == ST_EXEC) begin
                r_alu_res <= w_alu_res;
                r_alu_c   <= w_alu_c;
                r_alu_z   <= w_alu_z;
                r_alu_l   <= w_alu_l;
                r_br_take <= w_cond;
                // Target must already be stable while bra_taken is high in WB.
                if (w_cond) begin
                    r_bra_target <= w_s;
                end
            end

            if (r_state == ST_WB) begin
                case (w_op)
                    c_OP_LD,
                    c_OP_XOR,
                    c_OP_ROT,
                    c_OP_SHF: begin
                        r_regs[w_dst_ridx] <= r_alu_res;
                        r_res              <= r_alu_res;
                    end
                    c_OP_ADD: begin
                        r_regs[w_dst_ridx] <= r_alu_res;
                        r_res              <= r_alu_res;
                        r_c                <= r_alu_c;
                    end
                    c_OP_STR: begin
                        r_mem[w_dst_midx] <= r_alu_res;
                        r_res             <= r_alu_res;
                    end
                    c_OP_CMP: begin
                        r_z <= r_alu_z;
                        r_l <= r_alu_l;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bra_taken  = (r_state == ST_WB) && r_br_take;
    assign bra_target = r_bra_target;
    assign Res        = r_res;

endmodule

`default_nettype wire

// File: tb/tb_instr_exec.sv
// ============================================================================
//  Module      : tb_instr_exec
//  Description : Self-checking bench for instr_exec. A behavioural model
//                predicts each instruction's outcome, pushes it to a queue,
//                and the queue is popped against the DUT outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_exec;
    import isa_pkg::*;

    localparam int c_W  = 32;
    localparam int c_IW = 4 + 2 * c_W + 1;

    typedef struct {
        logic [c_W-1:0] res;
        logic           taken;
        logic [c_W-1:0] tgt;
        logic           halt;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [c_IW-1:0] instr = '0;
    logic            instr_valid = 1'b0;
    logic            instr_ready;
    logic            bra_taken;
    logic [c_W-1:0]  bra_target;
    logic [c_W-1:0]  Res;
    logic            done;

    instr_exec #(
        .BUSW        (32),
        .OPW         (4),
        .NREG        (16),
        .NMEM        (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .bra_taken   (bra_taken),
        .bra_target  (bra_target),
        .Res         (Res),
        .done        (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_checks = 0;
    int   n_errors = 0;
    int   last_hs_cyc = 0;
    exp_t exp_q[$];

    // Reference model state
    logic [c_W-1:0] m_reg [16];
    logic [c_W-1:0] m_mem [16];
    logic           m_z, m_c, m_l;
    logic [c_W-1:0] m_res;

    task automatic chk(input string tag, input logic [c_W-1:0] got, input logic [c_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_reg[i] = '0;
            m_mem[i] = '0;
        end
        m_z = 1'b0; m_c = 1'b0; m_l = 1'b0;
        m_res = '0;
    endtask

    task automatic model(input logic [3:0] op, input logic [c_W-1:0] dst,
                         input logic [c_W-1:0] src, input logic lit, output exp_t e);
        logic [c_W-1:0] s, a, r;
        logic [c_W:0]   sum;
        logic           cond;
        s = lit ? src : m_reg[src[3:0]];
        a = m_reg[dst[3:0]];
        e.taken = 1'b0; e.tgt = '0; e.halt = 1'b0;
        case (op)
            c_OP_LD:  begin m_reg[dst[3:0]] = lit ? src : m_mem[src[3:0]]; m_res = m_reg[dst[3:0]]; end
            c_OP_STR: begin m_mem[dst[3:0]] = s; m_res = s; end
            c_OP_ADD: begin sum = a + s; m_c = sum[c_W]; m_reg[dst[3:0]] = sum[c_W-1:0]; m_res = sum[c_W-1:0]; end
            c_OP_XOR: begin m_reg[dst[3:0]] = a ^ s; m_res = a ^ s; end
            c_OP_ROT: begin
                r = a;
                for (int k = 0; k < (s % 32); k++) r = {r[c_W-2:0], r[c_W-1]};
                m_reg[dst[3:0]] = r; m_res = r;
            end
            c_OP_SHF: begin
                r = (s >= 32) ? '0 : (a << s);
                m_reg[dst[3:0]] = r; m_res = r;
            end
            c_OP_CMP: begin m_z = (a == s); m_l = (a < s); end
            c_OP_BRA: begin
                case (dst[1:0])
                    2'd0:    cond = 1'b1;
                    2'd1:    cond = m_z;
                    2'd2:    cond = m_c;
                    default: cond = m_l;
                endcase
                e.taken = cond;
                e.tgt   = cond ? s : '0;
            end
            c_OP_HLT: e.halt = 1'b1;
            default: ;
        endcase
        e.res = m_res;
    endtask

    function automatic logic [c_IW-1:0] mk(input logic [3:0] op, input logic [c_W-1:0] dst,
                                           input logic [c_W-1:0] src, input logic lit);
        return {op, dst, src, lit};
    endfunction

    // Called at a negedge; returns at the negedge following the handshake edge.
    task automatic handshake(input string tag, input logic [c_IW-1:0] word);
        int guard;
        guard = 0;
        instr       = word;
        instr_valid = 1'b1;
        while (!instr_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) begin
            chk({tag, "_hs_timeout"}, 32'd0, 32'd1);
        end
        @(posedge clk);
        #1;
        last_hs_cyc = cyc;
        instr_valid = 1'b0;
        instr       = {$urandom, $urandom, $urandom};
        @(negedge clk);
    endtask

    task automatic retire(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        // EXEC cycle (N+1)
        chk({tag, "_rdy_exec"}, instr_ready, 32'd0);
        chk({tag, "_bra_exec"}, bra_taken, 32'd0);
        @(negedge clk);
        // WB cycle (N+2)
        chk({tag, "_rdy_wb"}, instr_ready, 32'd0);
        chk({tag, "_bra_taken"}, bra_taken, e.taken);
        if (e.taken) chk({tag, "_bra_target"}, bra_target, e.tgt);
        chk({tag, "_done_wb"}, done, 32'd0);
        @(negedge clk);
        // N+3
        chk({tag, "_res"}, Res, e.res);
        chk({tag, "_done"}, done, e.halt);
        chk({tag, "_rdy_next"}, instr_ready, !e.halt);
        chk({tag, "_bra_after"}, bra_taken, 32'd0);
    endtask

    task automatic send(input string tag, input logic [3:0] op, input logic [c_W-1:0] dst,
                        input logic [c_W-1:0] src, input logic lit);
        exp_t e;
        model(op, dst, src, lit, e);
        exp_q.push_back(e);
        handshake(tag, mk(op, dst, src, lit));
        retire(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    initial begin
        int first_hs;
        int hi;
        model_reset();

        // ---- reset state ----
        repeat (3) @(negedge clk);
        chk("rst_ready", instr_ready, 32'd0);
        chk("rst_done", done, 32'd0);
        chk("rst_res", Res, 32'd0);
        chk("rst_bra_taken", bra_taken, 32'd0);
        chk("rst_bra_target", bra_target, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_release_ready", instr_ready, 32'd1);

        // ---- program 1: store/load/add/store/halt back-to-back ----
        send("p1_str", c_OP_STR, 1, 2, 1'b1);
        first_hs = last_hs_cyc;
        send("p1_ld",  c_OP_LD,  1, 1, 1'b0);
        send("p1_add", c_OP_ADD, 1, 3, 1'b1);
        send("p1_str2", c_OP_STR, 2, 1, 1'b0);
        send("p1_hlt", c_OP_HLT, 0, 0, 1'b1);
        chk("p1_res5", Res, 32'd5);
        // Handshake cycle is N; N+15 is reached 14 edges after it.
        chk("p1_done_cycle", cyc - first_hs, 32'd14);
        hi = 0;
        instr_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (instr_ready) hi++;
        end
        instr_valid = 1'b0;
        chk("p1_halt_ready_low", hi, 32'd0);
        chk("p1_done_sticky", done, 32'd1);

        // ---- program 2: carry and conditional branch ----
        do_reset();
        send("p2_ld",  c_OP_LD,  0, 32'hFFFF_FFFF, 1'b1);
        send("p2_add", c_OP_ADD, 0, 1, 1'b1);
        send("p2_bra_c", c_OP_BRA, {30'd0, c_COND_C}, 7, 1'b1);

        // ---- program 3: rotate and shift boundaries ----
        send("p3_ld",  c_OP_LD,  3, 32'h8000_0001, 1'b1);
        send("p3_rot", c_OP_ROT, 3, 33, 1'b1);
        chk("p3_rot_val", Res, 32'h0000_0003);
        send("p3_shf", c_OP_SHF, 3, 32, 1'b1);

        // ---- program 4: compare and flag branches ----
        send("p4_ld",  c_OP_LD,  4, 4, 1'b1);
        send("p4_cmp", c_OP_CMP, 4, 9, 1'b1);
        send("p4_bra_z", c_OP_BRA, {30'd0, c_COND_Z}, 5, 1'b1);
        send("p4_bra_l", c_OP_BRA, {30'd0, c_COND_L}, 2, 1'b1);
        send("p4_xor0", c_OP_XOR, 4, 0, 1'b1);

        // ---- program 5: idle FETCH, then unknown opcode ----
        hi = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (instr_ready) hi++;
        end
        chk("p5_idle_ready", hi, 32'd10);
        send("p5_unk", 4'hF, 4, 32'h1234, 1'b1);

        // ---- program 6: reset during EXEC aborts the store ----
        handshake("p6_str", mk(c_OP_STR, 5, 9, 1'b1));
        rst = 1'b1;            // EXEC cycle: reset sampled at the EXEC->WB edge
        @(negedge clk);
        chk("p6_ready", instr_ready, 32'd0);
        chk("p6_bra_taken", bra_taken, 32'd0);
        chk("p6_bra_target", bra_target, 32'd0);
        chk("p6_res", Res, 32'd0);
        chk("p6_done", done, 32'd0);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk("p6_bra_no_pulse", bra_taken, 32'd0);
        chk("p6_ready_back", instr_ready, 32'd1);
        send("p6_ld_mem5", c_OP_LD, 6, 5, 1'b0);
        send("p6_ld_lit", c_OP_LD, 7, 32'hA5A5_0001, 1'b1);
        send("p6_ld_mem5b", c_OP_LD, 8, 5, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
